motor_softstart_pwm: RTL and testbench
======================================

Name: motor_softstart_pwm

Overview:
- Downstream stage of the hybrid-drive mode controller.
- Consumes its level-type motor enables MOTOR1 (electric) and MOTOR2 (combustion/starter).
- Converts each enable into a soft-started PWM drive signal with a controlled duty ramp up and down.
- Reports per-motor duty, at-speed status, and an emergency-stop override to the power stage.

Parameters:
- PWM_BITS, 6: width of PWM counter and duty; PWM period = 2^PWM_BITS cycles; DUTY_MAX = 2^PWM_BITS-1.
- RAMP_STEP, 8: duty increment/decrement applied per ramp tick.
- RAMP_DIV, 4: CLK cycles per ramp tick (>=1).

Ports:
- CLK  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- MOTOR1  in  1  electric motor run request (level)
- MOTOR2  in  1  combustion motor run request (level)
- ESTOP  in  1  emergency stop, synchronous, active-high, overrides requests
- PWM1  out  1  PWM drive, motor 1
- PWM2  out  1  PWM drive, motor 2
- DUTY1  out  PWM_BITS  current duty, motor 1
- DUTY2  out  PWM_BITS  current duty, motor 2
- AT_SPEED1  out  1  motor 1 in FULL state
- AT_SPEED2  out  1  motor 2 in FULL state
- BUSY  out  1  either channel in RAMP_UP or RAMP_DOWN

Behaviour:
- Interface: reset reset, synchronous, active-high; clock CLK.
- Reset values:
  - all outputs 0; both channels OFF; duties 0.
  - PWM counter and ramp prescaler 0.
- Shared timebase:
  - PWM counter CNT free-runs 0..DUTY_MAX and wraps.
  - Ramp prescaler counts 0..RAMP_DIV-1; TICK=1 in the cycle it equals RAMP_DIV-1, then it wraps to 0.
  - RAMP_DIV=1 gives TICK every cycle.
- Per-channel FSM (states OFF, RAMP_UP, FULL, RAMP_DOWN), REQ = MOTORx:
  - OFF: duty=0. REQ=1 -> RAMP_UP.
  - RAMP_UP:
    - On TICK, duty = min(duty+RAMP_STEP, DUTY_MAX). Compute in PWM_BITS+1 bits, then saturate.
    - When the registered duty equals DUTY_MAX -> FULL.
    - REQ=0 -> RAMP_DOWN next cycle; duty holds its value at that point.
  - FULL: duty=DUTY_MAX. REQ=0 -> RAMP_DOWN.
  - RAMP_DOWN:
    - On TICK, duty = max(duty-RAMP_STEP, 0), no underflow wrap.
    - Registered duty==0 -> OFF.
    - REQ=1 -> RAMP_UP from current duty, no reset to 0.
- Transitions are evaluated on registered state/duty. Duty update and state change may occur in the same cycle only as listed above.
- Channels are independent. Simultaneous requests ramp in lockstep off the shared TICK.
- ESTOP=1:
  - Next edge: both channels OFF, duties 0, PWM 0, AT_SPEED 0.
  - While held, channels stay OFF regardless of REQ.
  - On release with REQ=1, a channel enters RAMP_UP the following cycle from duty 0.
- PWM:
  - PWMx registered; PWMx = (CNT < DUTYx), except DUTYx==DUTY_MAX forces PWMx=1 for the whole period.
  - One cycle latency from CNT/DUTY to pin.
  - Duty changes take effect at the next compare, with no period alignment required.
- AT_SPEEDx and BUSY are registered, derived from next-state values so they align with the state register.
- reset asserted mid-ramp: same as power-on reset, with no residual duty.
- An unreachable state encoding returns the channel to OFF with duty 0.

Decomposition:
- Package motor_drive_pkg holds:
  - channel state encoding (one-hot, 4 bits: OFF, RAMP_UP, FULL, RAMP_DOWN)
  - DUTY_MAX derivation function
  - default parameter constants
- Sub-module motor_ramp_channel contains one FSM, its duty register, PWM compare and AT_SPEED.
- It is instantiated twice. The top owns CNT, the prescaler, ESTOP fan-out and the BUSY OR.

Test Plan:
- Defaults; reset 3 cycles, MOTOR1=1 -> DUTY1 goes 8,16,...,56,63 over 8 TICKs (32 cycles), then AT_SPEED1=1 and PWM1 constant 1; BUSY=1 during the ramp.
- From FULL, drop MOTOR1 -> DUTY1 goes 55,47,...,7,0 over 8 TICKs, then OFF; AT_SPEED1 deasserts on the first cycle after the drop.
- MOTOR2=1 for 3 TICKs (duty 24), then 0 for 1 TICK (16), then 1 again -> resumes 24,32,... with no drop to 0.
- DUTY1=16 steady -> PWM1 high exactly 16 of every 64 cycles, 1-cycle lag after CNT=0.
- Both motors ramping, ESTOP pulse 1 cycle at duty 40 -> both duties 0 next cycle; with requests still high, both restart from 0 and reach 63 after 8 TICKs.
- reset asserted mid-RAMP_DOWN (duty 32) -> all outputs 0 next edge; MOTOR1 held low after release -> stays OFF.

Source files
------------

// File: rtl/motor_drive_pkg.sv
// motor_drive_pkg - shared channel state encoding and default constants for the soft-start PWM drive.
// Rev 1.0
`default_nettype none

package motor_drive_pkg;

  localparam int PWM_BITS_DEF  = 6;
  localparam int RAMP_STEP_DEF = 8;
  localparam int RAMP_DIV_DEF  = 4;

  typedef enum logic [3:0] {
    CH_OFF       = 4'b0001,
    CH_RAMP_UP   = 4'b0010,
    CH_FULL      = 4'b0100,
    CH_RAMP_DOWN = 4'b1000
  } ch_state_t;

  function automatic int duty_max(input int bits);
    return (1 << bits) - 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/motor_ramp_channel.sv
// motor_ramp_channel - one soft-start channel: ramp FSM, duty register, PWM compare, at-speed flag.
// Rev 1.0
`default_nettype none

module motor_ramp_channel
  import motor_drive_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                estop,
  input  logic                req,
  input  logic                tick,
  input  logic [PWM_BITS-1:0] cnt,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic                at_speed,
  output logic                ramping_next
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = PWM_BITS'(duty_max(PWM_BITS));
  localparam logic [PWM_BITS:0]   STEP     = (PWM_BITS+1)'(RAMP_STEP);

  ch_state_t           state;
  ch_state_t           state_n;
  logic [PWM_BITS-1:0] duty_n;
  logic [PWM_BITS:0]   up_sum;
  logic [PWM_BITS-1:0] up_sat;
  logic [PWM_BITS-1:0] down_sat;

  // One extra bit on the way up so the saturation check sees the carry.
  assign up_sum   = {1'b0, duty} + STEP;
  assign up_sat   = (up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum[PWM_BITS-1:0];
  assign down_sat = ({1'b0, duty} <= STEP) ? '0 : (duty - STEP[PWM_BITS-1:0]);

  always_comb begin
    state_n = state;
    duty_n  = duty;
    case (state)
      CH_OFF: begin
        duty_n = '0;
        if (req) state_n = CH_RAMP_UP;
      end
      CH_RAMP_UP: begin
        if (!req)                  state_n = CH_RAMP_DOWN;
        else if (duty == DUTY_MAX) state_n = CH_FULL;
        else if (tick)             duty_n  = up_sat;
      end
      CH_FULL: begin
        duty_n = DUTY_MAX;
        if (!req) state_n = CH_RAMP_DOWN;
      end
      CH_RAMP_DOWN: begin
        if (req)             state_n = CH_RAMP_UP;
        else if (duty == '0) state_n = CH_OFF;
        else if (tick)       duty_n  = down_sat;
      end
      default: begin
        state_n = CH_OFF;
        duty_n  = '0;
      end
    endcase
    if (estop) begin
      state_n = CH_OFF;
      duty_n  = '0;
    end
  end

  assign ramping_next = (state_n == CH_RAMP_UP) || (state_n == CH_RAMP_DOWN);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state    <= CH_OFF;
      duty     <= '0;
      pwm      <= 1'b0;
      at_speed <= 1'b0;
    end else begin
      state    <= state_n;
      duty     <= duty_n;
      at_speed <= (state_n == CH_FULL);
      // Full duty holds the pin high across the counter wrap instead of dropping for one count.
      pwm      <= !estop && ((duty == DUTY_MAX) || (cnt < duty));
    end
  end

endmodule

`default_nettype wire

// File: rtl/motor_softstart_pwm.sv
// motor_softstart_pwm - two soft-started PWM motor drives sharing one PWM counter and ramp prescaler.
// Rev 1.0
`default_nettype none

module motor_softstart_pwm
  import motor_drive_pkg::*;
#(
  parameter int PWM_BITS  = PWM_BITS_DEF,
  parameter int RAMP_STEP = RAMP_STEP_DEF,
  parameter int RAMP_DIV  = RAMP_DIV_DEF
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                MOTOR1,
  input  logic                MOTOR2,
  input  logic                ESTOP,
  output logic                PWM1,
  output logic                PWM2,
  output logic [PWM_BITS-1:0] DUTY1,
  output logic [PWM_BITS-1:0] DUTY2,
  output logic                AT_SPEED1,
  output logic                AT_SPEED2,
  output logic                BUSY
);

  localparam int              PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(RAMP_DIV - 1);

  logic [PWM_BITS-1:0] cnt;
  logic [PRE_W-1:0]    pre;
  logic                tick;
  logic                ramping1;
  logic                ramping2;

  assign tick = (pre == PRE_LAST);

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt  <= '0;
      pre  <= '0;
      BUSY <= 1'b0;
    end else begin
      cnt  <= cnt + 1'b1;
      pre  <= tick ? '0 : pre + 1'b1;
      BUSY <= ramping1 | ramping2;
    end
  end

  motor_ramp_channel #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_ch1 (
    .CLK          (CLK),
    .reset        (reset),
    .estop        (ESTOP),
    .req          (MOTOR1),
    .tick         (tick),
    .cnt          (cnt),
    .pwm          (PWM1),
    .duty         (DUTY1),
    .at_speed     (AT_SPEED1),
    .ramping_next (ramping1)
  );

  motor_ramp_channel #(
    .PWM_BITS  (PWM_BITS),
    .RAMP_STEP (RAMP_STEP)
  ) u_ch2 (
    .CLK          (CLK),
    .reset        (reset),
    .estop        (ESTOP),
    .req          (MOTOR2),
    .tick         (tick),
    .cnt          (cnt),
    .pwm          (PWM2),
    .duty         (DUTY2),
    .at_speed     (AT_SPEED2),
    .ramping_next (ramping2)
  );

endmodule

`default_nettype wire

// File: tb/tb_motor_softstart_pwm.sv
// tb_motor_softstart_pwm - directed self-checking bench for motor_softstart_pwm at default parameters.
// Rev 1.0
`default_nettype none

module tb_motor_softstart_pwm;

  logic       CLK = 1'b0;
  logic       reset;
  logic       MOTOR1;
  logic       MOTOR2;
  logic       ESTOP;
  logic       PWM1;
  logic       PWM2;
  logic [5:0] DUTY1;
  logic [5:0] DUTY2;
  logic       AT_SPEED1;
  logic       AT_SPEED2;
  logic       BUSY;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hi;

  always #5 CLK = ~CLK;

  motor_softstart_pwm #(
    .PWM_BITS  (6),
    .RAMP_STEP (8),
    .RAMP_DIV  (4)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .MOTOR1    (MOTOR1),
    .MOTOR2    (MOTOR2),
    .ESTOP     (ESTOP),
    .PWM1      (PWM1),
    .PWM2      (PWM2),
    .DUTY1     (DUTY1),
    .DUTY2     (DUTY2),
    .AT_SPEED1 (AT_SPEED1),
    .AT_SPEED2 (AT_SPEED2),
    .BUSY      (BUSY)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // cyc counts edges since reset release; ticks land on edges where cyc % 4 == 0.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic step_to_tick();
    do step(); while (cyc % 4 != 0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    MOTOR1 = 1'b0;
    MOTOR2 = 1'b0;
    ESTOP  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // Reset values
    do_reset();
    check("reset_outputs", {PWM1, PWM2, AT_SPEED1, AT_SPEED2, BUSY, DUTY1, DUTY2}, 0);

    // Motor 1 ramp up 8,16,...,56,63
    MOTOR1 = 1'b1;
    step();
    check("up_busy_start", BUSY, 1);
    check("up_duty_start", DUTY1, 0);
    for (int k = 1; k <= 8; k++) begin
      step_to_tick();
      check("up_duty1", DUTY1, (k == 8) ? 63 : 8 * k);
      check("up_busy", BUSY, 1);
    end
    check("up_not_yet_full", AT_SPEED1, 0);
    step();
    check("full_at_speed1", AT_SPEED1, 1);
    check("full_busy_clear", BUSY, 0);
    hi = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      hi += int'(PWM1);
    end
    check("full_pwm_high_count", hi, 64);

    // Ramp down from FULL 55,47,...,7,0
    MOTOR1 = 1'b0;
    step();
    check("down_at_speed_drop", AT_SPEED1, 0);
    check("down_duty_hold", DUTY1, 63);
    check("down_busy", BUSY, 1);
    for (int k = 1; k <= 8; k++) begin
      step_to_tick();
      check("down_duty1", DUTY1, (k == 8) ? 0 : 63 - 8 * k);
    end
    step();
    check("down_off_busy", BUSY, 0);
    check("down_off_duty", DUTY1, 0);

    // Motor 2 interrupted ramp resumes from current duty
    do_reset();
    MOTOR2 = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) begin
      step_to_tick();
      check("m2_up_duty2", DUTY2, 8 * k);
    end
    MOTOR2 = 1'b0;
    step();
    check("m2_hold_on_drop", DUTY2, 24);
    step_to_tick();
    check("m2_down_one_tick", DUTY2, 16);
    MOTOR2 = 1'b1;
    step();
    check("m2_no_drop_on_resume", DUTY2, 16);
    check("m2_resume_busy", BUSY, 1);
    step_to_tick();
    check("m2_resume_24", DUTY2, 24);
    step_to_tick();
    check("m2_resume_32", DUTY2, 32);
    check("m2_ch1_idle", DUTY1, 0);

    // Duty 16 held by toggling the request every cycle; PWM lags the counter by one cycle
    do_reset();
    MOTOR1 = 1'b1;
    step();
    step_to_tick();
    step_to_tick();
    check("pwm_duty_16", DUTY1, 16);
    hi = 0;
    for (int i = 0; i < 128; i++) begin
      MOTOR1 = ~MOTOR1;
      step();
      check("pwm_phase", PWM1, (((cyc - 1) % 64) < 16) ? 1 : 0);
      if (i >= 64) hi += int'(PWM1);
    end
    check("pwm_high_per_period", hi, 16);
    check("pwm_duty_steady", DUTY1, 16);

    // ESTOP pulse at duty 40, then restart from 0
    do_reset();
    MOTOR1 = 1'b1;
    MOTOR2 = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) step_to_tick();
    check("estop_pre_duty1", DUTY1, 40);
    check("estop_pre_duty2", DUTY2, 40);
    ESTOP = 1'b1;
    step();
    check("estop_duty1", DUTY1, 0);
    check("estop_duty2", DUTY2, 0);
    check("estop_pwm", {PWM1, PWM2}, 0);
    check("estop_busy", BUSY, 0);
    ESTOP = 1'b0;
    step();
    check("estop_restart_busy", BUSY, 1);
    check("estop_restart_duty", DUTY1, 0);
    for (int k = 1; k <= 8; k++) begin
      step_to_tick();
      check("estop_ramp_duty1", DUTY1, (k == 8) ? 63 : 8 * k);
      check("estop_ramp_duty2", DUTY2, (k == 8) ? 63 : 8 * k);
    end
    step();
    check("estop_full_both", {AT_SPEED1, AT_SPEED2}, 3);
    ESTOP = 1'b1;
    repeat (3) step();
    check("estop_held_off", {AT_SPEED1, AT_SPEED2, BUSY, DUTY1, DUTY2}, 0);
    ESTOP = 1'b0;

    // Reset during ramp down at duty 32
    do_reset();
    MOTOR1 = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) step_to_tick();
    MOTOR1 = 1'b0;
    step();
    check("rst_mid_hold_40", DUTY1, 40);
    step_to_tick();
    check("rst_mid_duty_32", DUTY1, 32);
    check("rst_mid_busy", BUSY, 1);
    reset = 1'b1;
    step();
    check("rst_mid_outputs", {PWM1, PWM2, AT_SPEED1, AT_SPEED2, BUSY, DUTY1, DUTY2}, 0);
    reset = 1'b0;
    repeat (10) step();
    check("rst_mid_stays_off", {PWM1, BUSY, DUTY1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
